// File: rtl/sbox_share_ctrl.sv
// Shares LANES AES S-box instances between the round datapath (16-byte SubBytes)
// and key expansion (4-byte SubWord) using 4-phase req/ack and round-robin grant.

module aes_sbox (
    input  logic [7:0] data,
    output logic [7:0] sub
);
    // Byte 0 of the table sits in the most significant bits.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [10:0] top_bit;

    assign top_bit = 11'd2047 - {data, 3'b000};
    assign sub     = SBOX_TABLE[top_bit -: 8];
endmodule

module sbox_share_ctrl #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rnd_req,
    input  logic [127:0] rnd_state,
    output logic         rnd_ack,
    output logic [127:0] rnd_result,
    input  logic         key_req,
    input  logic [31:0]  key_word,
    output logic         key_ack,
    output logic [31:0]  key_result,
    output logic         busy
);
    localparam int         RND_GROUPS = 16 / LANES;
    localparam int         KEY_GROUPS = 4 / LANES;
    localparam logic [3:0] RND_LAST   = 4'(RND_GROUPS - 1);
    localparam logic [3:0] KEY_LAST   = 4'(KEY_GROUPS - 1);

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_lanes_check
            $error("sbox_share_ctrl: LANES must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        RND_RUN,
        KEY_RUN,
        RND_ACK,
        KEY_ACK
    } state_t;

    state_t       state;
    logic [3:0]   cnt;
    logic         last_key;   // 1: the most recent grant went to key expansion
    logic [127:0] operand;    // key words are held in the top 32 bits
    logic [7:0]   lane_in  [LANES];
    logic [7:0]   lane_out [LANES];

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        aes_sbox u_sbox (
            .data (lane_in[l]),
            .sub  (lane_out[l])
        );
    end

    // Byte b of the operand belongs to group b/LANES and travels on lane b%LANES.
    always_comb begin
        // NOTE: every lane gets a default first so no path leaves it unassigned (no latch).
        for (int l = 0; l < LANES; l++) begin
            lane_in[l] = 8'h00;
        end
        for (int b = 0; b < 16; b++) begin
            if (4'(b / LANES) == cnt) begin
                lane_in[b % LANES] = operand[127 - 8*b -: 8];
            end
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            last_key   <= 1'b0;
            operand    <= '0;
            rnd_ack    <= 1'b0;
            key_ack    <= 1'b0;
            rnd_result <= '0;
            key_result <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rnd_req && (!key_req || last_key)) begin
                        operand  <= rnd_state;
                        last_key <= 1'b0;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= RND_RUN;
                    end else if (key_req) begin
                        operand  <= {key_word, 96'd0};
                        last_key <= 1'b1;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= KEY_RUN;
                    end
                end

                RND_RUN: begin
                    for (int b = 0; b < 16; b++) begin
                        if (4'(b / LANES) == cnt) begin
                            rnd_result[127 - 8*b -: 8] <= lane_out[b % LANES];
                        end
                    end
                    if (cnt == RND_LAST) begin
                        cnt     <= '0;
                        rnd_ack <= 1'b1;
                        state   <= RND_ACK;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end

                KEY_RUN: begin
                    for (int b = 0; b < 4; b++) begin
                        if (4'(b / LANES) == cnt) begin
                            key_result[31 - 8*b -: 8] <= lane_out[b % LANES];
                        end
                    end
                    if (cnt == KEY_LAST) begin
                        cnt     <= '0;
                        key_ack <= 1'b1;
                        state   <= KEY_ACK;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end

                RND_ACK: begin
                    if (!rnd_req) begin
                        rnd_ack <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end

                KEY_ACK: begin
                    if (!key_req) begin
                        key_ack <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sbox_share_ctrl.sv
// Bench for sbox_share_ctrl: runs LANES=1,2,4 side by side on shared stimulus and
// checks them against an S-box computed from GF(2^8) arithmetic.

module tb_sbox_share_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         rnd_req, key_req;
    logic [127:0] rnd_state;
    logic [31:0]  key_word;

    // Index d drives the instance with LANES = 1 << d.
    logic         rnd_ack    [3];
    logic         key_ack    [3];
    logic         busy       [3];
    logic [127:0] rnd_result [3];
    logic [31:0]  key_result [3];

    sbox_share_ctrl #(.LANES(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .rnd_req(rnd_req), .rnd_state(rnd_state), .rnd_ack(rnd_ack[0]), .rnd_result(rnd_result[0]),
        .key_req(key_req), .key_word(key_word), .key_ack(key_ack[0]), .key_result(key_result[0]),
        .busy(busy[0])
    );
    sbox_share_ctrl #(.LANES(2)) u_dut_l2 (
        .clk(clk), .rst_n(rst_n),
        .rnd_req(rnd_req), .rnd_state(rnd_state), .rnd_ack(rnd_ack[1]), .rnd_result(rnd_result[1]),
        .key_req(key_req), .key_word(key_word), .key_ack(key_ack[1]), .key_result(key_result[1]),
        .busy(busy[1])
    );
    sbox_share_ctrl #(.LANES(4)) u_dut_l4 (
        .clk(clk), .rst_n(rst_n),
        .rnd_req(rnd_req), .rnd_state(rnd_state), .rnd_ack(rnd_ack[2]), .rnd_result(rnd_result[2]),
        .key_req(key_req), .key_word(key_word), .key_ack(key_ack[2]), .key_result(key_result[2]),
        .busy(busy[2])
    );

    int           checks = 0;
    int           errors = 0;
    logic [7:0]   sb [256];
    bit           last_key;
    logic [127:0] exp_rnd;
    logic [31:0]  exp_key;
    int           lat [3];
    bit           busy_bad;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int lanes_of(input int d);
        return 1 << d;
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic       hi;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // AES S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = sb[s[127 - 8*i -: 8]];
        return r;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[31 - 8*i -: 8] = sb[w[31 - 8*i -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Counts edges until each instance raises the selected ack; -1 marks a timeout.
    task automatic wait_ack(input bit is_key, input int budget, input bit scramble);
        for (int d = 0; d < 3; d++) lat[d] = -1;
        busy_bad = 1'b0;
        for (int e = 1; e <= budget; e++) begin
            @(posedge clk); #1;
            if (scramble && e == 1) begin
                rnd_state = rand128();
                key_word  = $urandom;
            end
            for (int d = 0; d < 3; d++) begin
                if (lat[d] < 0) begin
                    if ((is_key ? key_ack[d] : rnd_ack[d]) === 1'b1) lat[d] = e;
                    else if (busy[d] !== 1'b1) busy_bad = 1'b1;
                end
            end
            if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
        end
    endtask

    task automatic check_results(input string tag);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("L%0d %s rnd_result", lanes_of(d), tag), rnd_result[d], exp_rnd);
            check($sformatf("L%0d %s key_result", lanes_of(d), tag), {96'd0, key_result[d]}, {96'd0, exp_key});
        end
    endtask

    task automatic check_idle(input string tag);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("L%0d %s acks/busy", lanes_of(d), tag),
                  {125'd0, rnd_ack[d], key_ack[d], busy[d]}, 128'd0);
        end
    endtask

    task automatic apply_reset();
        rst_n   = 1'b0;
        rnd_req = 1'b0;
        key_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        last_key = 1'b0;
        exp_rnd  = '0;
        exp_key  = '0;
        check_idle("reset");
        check_results("reset");
        rst_n = 1'b1;
    endtask

    // One handshake (or a tie pair) served in the order the round-robin rule dictates.
    task automatic do_op(input bit want_rnd, input bit want_key,
                         input logic [127:0] st, input logic [31:0] kw);
        bit first_key;
        bit both;
        both      = want_rnd && want_key;
        first_key = want_key && (!want_rnd || !last_key);
        rnd_state = st;
        key_word  = kw;
        rnd_req   = want_rnd;
        key_req   = want_key;

        wait_ack(first_key, 40, !both);
        last_key = first_key;
        if (first_key) exp_key = sub_word(kw);
        else           exp_rnd = sub_bytes(st);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("L%0d first latency", lanes_of(d)), lat[d],
                  1 + (first_key ? 4 : 16) / lanes_of(d));
            check($sformatf("L%0d other ack idle", lanes_of(d)),
                  first_key ? rnd_ack[d] : key_ack[d], 1'b0);
        end
        check("busy during run", busy_bad, 1'b0);
        check_results("first");
        if (first_key) key_req = 1'b0;
        else           rnd_req = 1'b0;

        if (both) begin
            wait_ack(!first_key, 60, 1'b0);
            last_key = !first_key;
            if (first_key) exp_rnd = sub_bytes(st);
            else           exp_key = sub_word(kw);
            for (int d = 0; d < 3; d++) begin
                check($sformatf("L%0d second latency", lanes_of(d)), lat[d],
                      2 + (first_key ? 16 : 4) / lanes_of(d));
            end
            check_results("second");
            rnd_req = 1'b0;
            key_req = 1'b0;
        end

        @(posedge clk); #1;
        check_idle("after drop");
    endtask

    initial begin
        logic [127:0] st;
        int           rise [3];
        int           fall [3];

        rst_n     = 1'b0;
        rnd_req   = 1'b0;
        key_req   = 1'b0;
        rnd_state = '0;
        key_word  = '0;
        build_sbox();
        apply_reset();

        // Known-answer vectors.
        do_op(1'b0, 1'b1, rand128(), 32'hcf4f3c09);
        check("key KAT", {96'd0, key_result[2]}, {96'd0, 32'h8a84eb01});
        do_op(1'b1, 1'b0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, $urandom);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("L%0d round KAT", lanes_of(d)), rnd_result[d],
                  128'hd42711aee0bf98f1b8b45de51e415230);
        end

        // Ties from reset: key first, then a key-only op so the next tie goes to round.
        apply_reset();
        do_op(1'b1, 1'b1, rand128(), $urandom);
        do_op(1'b0, 1'b1, rand128(), $urandom);
        do_op(1'b1, 1'b1, rand128(), $urandom);

        for (int i = 0; i < 10; i++) begin
            case ($urandom_range(0, 2))
                0:       do_op(1'b1, 1'b0, rand128(), $urandom);
                1:       do_op(1'b0, 1'b1, rand128(), $urandom);
                default: do_op(1'b1, 1'b1, rand128(), $urandom);
            endcase
        end

        // Request dropped during RUN: ack appears once and falls on the next edge.
        st        = rand128();
        rnd_state = st;
        rnd_req   = 1'b1;
        @(posedge clk); #1;
        rnd_req = 1'b0;
        for (int d = 0; d < 3; d++) begin
            rise[d] = -1;
            fall[d] = -1;
        end
        for (int e = 2; e <= 40; e++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                if (rise[d] < 0 && rnd_ack[d] === 1'b1) rise[d] = e;
                else if (rise[d] >= 0 && fall[d] < 0 && rnd_ack[d] !== 1'b1) fall[d] = e;
            end
            if (fall[0] >= 0 && fall[1] >= 0 && fall[2] >= 0) break;
        end
        last_key = 1'b0;
        exp_rnd  = sub_bytes(st);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("L%0d early drop rise", lanes_of(d)), rise[d], 1 + 16 / lanes_of(d));
            check($sformatf("L%0d early drop fall", lanes_of(d)), fall[d], 2 + 16 / lanes_of(d));
        end
        check_results("early drop");

        // Hold req through ACK while the input changes after grant.
        st             = rand128();
        st[127:120]    = 8'h53;
        rnd_state      = st;
        rnd_req        = 1'b1;
        wait_ack(1'b0, 40, 1'b1);
        exp_rnd = sub_bytes(st);
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("L%0d ack held", lanes_of(d)), rnd_ack[d], 1'b1);
            check($sformatf("L%0d byte0 53", lanes_of(d)), rnd_result[d][127:120], 8'hed);
        end
        check_results("held");
        rnd_req = 1'b0;
        @(posedge clk); #1;
        check_idle("hold release");

        // Asynchronous reset in the middle of a round operation.
        rnd_state = rand128();
        rnd_req   = 1'b1;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        last_key = 1'b0;
        exp_rnd  = '0;
        exp_key  = '0;
        check_idle("async reset");
        check_results("async reset");
        rnd_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_op(1'b1, 1'b0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, $urandom);
        check("post-reset round KAT", rnd_result[0], 128'hd42711aee0bf98f1b8b45de51e415230);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
